// File: rtl/btb_table.sv
// Set-associative branch target buffer: registered one-cycle lookup, update port with
// round-robin replacement and invalidate, and a per-set sweep engine for init and flush.
module btb_table #(
  parameter int PC_WIDTH    = 64,
  parameter int NUM_SETS    = 64,
  parameter int NUM_WAYS    = 4,
  parameter int TAG_BITS    = 20,
  parameter int OFFSET_BITS = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  output logic                busy,
  input  logic                req_valid,
  input  logic [PC_WIDTH-1:0] req_pc,
  output logic                resp_valid,
  output logic                resp_hit,
  output logic [PC_WIDTH-1:0] resp_target,
  output logic                resp_is_br,
  output logic                resp_is_jal,
  input  logic                update_valid,
  input  logic [PC_WIDTH-1:0] update_pc,
  input  logic [PC_WIDTH-1:0] update_target,
  input  logic                update_is_br,
  input  logic                update_is_jal,
  input  logic                update_invalidate
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [1:0] {ST_INIT, ST_FLUSH, ST_IDLE} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   ctr_q;
  logic               busy_q;
  logic               sweeping;

  logic               valid_q  [NUM_SETS][NUM_WAYS];
  logic [TAG_BITS-1:0] tag_q   [NUM_SETS][NUM_WAYS];
  logic [PC_WIDTH-1:0] target_q[NUM_SETS][NUM_WAYS];
  logic               is_br_q  [NUM_SETS][NUM_WAYS];
  logic               is_jal_q [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]   rr_q     [NUM_SETS];
  logic [WAY_W-1:0]   rr_d     [NUM_SETS];

  logic [IDX_W-1:0]    req_idx, upd_idx;
  logic [TAG_BITS-1:0] req_tag, upd_tag;
  logic                lk_hit, u_hit, u_free;
  logic [WAY_W-1:0]    lk_way, u_hit_way, u_free_way, wr_way;
  logic                wr_en, clr_en;

  logic                resp_valid_d, resp_hit_d, resp_is_br_d, resp_is_jal_d;
  logic [PC_WIDTH-1:0] resp_target_d;

  // Bits outside index+tag are intentionally ignored (aliasing allowed).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{req_pc, update_pc};

  assign req_idx  = req_pc[OFFSET_BITS +: IDX_W];
  assign req_tag  = req_pc[OFFSET_BITS + IDX_W +: TAG_BITS];
  assign upd_idx  = update_pc[OFFSET_BITS +: IDX_W];
  assign upd_tag  = update_pc[OFFSET_BITS + IDX_W +: TAG_BITS];
  assign sweeping = (state_q != ST_IDLE);
  assign busy     = busy_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      ctr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT, ST_FLUSH: begin
          if (ctr_q == IDX_W'(NUM_SETS - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            ctr_q   <= '0;
          end else begin
            ctr_q <= ctr_q + IDX_W'(1);
          end
        end
        ST_IDLE: begin
          if (flush) begin
            state_q <= ST_FLUSH;
            busy_q  <= 1'b1;
            ctr_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_INIT;
          busy_q  <= 1'b1;
          ctr_q   <= '0;
        end
      endcase
    end
  end

  // Descending scans so the lowest-indexed matching way is the one kept.
  always_comb begin
    lk_hit     = 1'b0;
    lk_way     = '0;
    u_hit      = 1'b0;
    u_hit_way  = '0;
    u_free     = 1'b0;
    u_free_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
      if (valid_q[upd_idx][w] && tag_q[upd_idx][w] == upd_tag) begin
        u_hit     = 1'b1;
        u_hit_way = WAY_W'(w);
      end
      if (!valid_q[upd_idx][w]) begin
        u_free     = 1'b1;
        u_free_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    wr_en  = 1'b0;
    clr_en = 1'b0;
    wr_way = '0;
    rr_d   = rr_q;
    if (sweeping) begin
      rr_d[ctr_q] = '0;
    end else if (update_valid) begin
      if (u_hit) begin
        wr_way = u_hit_way;
        clr_en = update_invalidate;
        wr_en  = !update_invalidate;
      end else if (!update_invalidate) begin
        wr_en = 1'b1;
        if (u_free) begin
          wr_way = u_free_way;
        end else begin
          wr_way        = rr_q[upd_idx];
          rr_d[upd_idx] = (rr_q[upd_idx] == WAY_W'(NUM_WAYS - 1)) ? '0
                                                                 : rr_q[upd_idx] + WAY_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Entry storage carries no reset; the init sweep clears the valid bits.
  always_ff @(posedge clock) begin
    if (sweeping) begin
      for (int w = 0; w < NUM_WAYS; w++) valid_q[ctr_q][w] <= 1'b0;
    end
    if (clr_en) valid_q[upd_idx][wr_way] <= 1'b0;
    if (wr_en) begin
      valid_q[upd_idx][wr_way]  <= 1'b1;
      tag_q[upd_idx][wr_way]    <= upd_tag;
      target_q[upd_idx][wr_way] <= update_target;
      is_br_q[upd_idx][wr_way]  <= update_is_br;
      is_jal_q[upd_idx][wr_way] <= update_is_jal;
    end
  end

  always_comb begin
    resp_valid_d  = req_valid;
    resp_hit_d    = req_valid && !sweeping && lk_hit;
    resp_target_d = resp_hit_d ? target_q[req_idx][lk_way] : '0;
    resp_is_br_d  = resp_hit_d && is_br_q[req_idx][lk_way];
    resp_is_jal_d = resp_hit_d && is_jal_q[req_idx][lk_way];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_target <= '0;
      resp_is_br  <= 1'b0;
      resp_is_jal <= 1'b0;
    end else begin
      resp_valid  <= resp_valid_d;
      resp_hit    <= resp_hit_d;
      resp_target <= resp_target_d;
      resp_is_br  <= resp_is_br_d;
      resp_is_jal <= resp_is_jal_d;
    end
  end

endmodule

// File: tb/tb_btb_table.sv
// Directed bench for btb_table with 16 sets x 2 ways; all set-0 PCs below share index 0.
module tb_btb_table;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        busy;
  logic        req_valid;
  logic [63:0] req_pc;
  logic        resp_valid;
  logic        resp_hit;
  logic [63:0] resp_target;
  logic        resp_is_br;
  logic        resp_is_jal;
  logic        update_valid;
  logic [63:0] update_pc;
  logic [63:0] update_target;
  logic        update_is_br;
  logic        update_is_jal;
  logic        update_invalidate;

  int checks   = 0;
  int failures = 0;
  int n;

  btb_table #(
    .PC_WIDTH(64), .NUM_SETS(16), .NUM_WAYS(2), .TAG_BITS(20), .OFFSET_BITS(1)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush), .busy(busy),
    .req_valid(req_valid), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_target(resp_target),
    .resp_is_br(resp_is_br), .resp_is_jal(resp_is_jal),
    .update_valid(update_valid), .update_pc(update_pc), .update_target(update_target),
    .update_is_br(update_is_br), .update_is_jal(update_is_jal),
    .update_invalidate(update_invalidate)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic upd(input logic [63:0] pc, input logic [63:0] tgt,
                     input logic br, input logic jal, input logic inv);
    update_valid      = 1'b1;
    update_pc         = pc;
    update_target     = tgt;
    update_is_br      = br;
    update_is_jal     = jal;
    update_invalidate = inv;
    tick();
    update_valid      = 1'b0;
    update_invalidate = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [63:0] pc, input logic hit,
                        input logic [63:0] tgt, input logic br, input logic jal);
    req_valid = 1'b1;
    req_pc    = pc;
    tick();
    req_valid = 1'b0;
    chk({tag, ".vld"}, 64'(resp_valid), 64'd1);
    chk({tag, ".hit"}, 64'(resp_hit), 64'(hit));
    chk({tag, ".tgt"}, resp_target, tgt);
    chk({tag, ".br"},  64'(resp_is_br), 64'(br));
    chk({tag, ".jal"}, 64'(resp_is_jal), 64'(jal));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; flush = 1'b0;
    req_valid = 1'b1; req_pc = 64'h1000;
    update_valid = 1'b0; update_pc = '0; update_target = '0;
    update_is_br = 1'b0; update_is_jal = 1'b0; update_invalidate = 1'b0;
    tick(); tick();
    chk("rst.busy", 64'(busy), 64'd1);
    chk("rst.resp_valid", 64'(resp_valid), 64'd0);

    // Reset release: request in the first sweep cycle, then count busy cycles.
    reset = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
      req_valid = 1'b0;
      if (n == 1) begin
        chk("init_req.vld", 64'(resp_valid), 64'd1);
        chk("init_req.hit", 64'(resp_hit), 64'd0);
        chk("init_req.tgt", resp_target, 64'd0);
      end
    end
    chk("init_len", 64'(n), 64'd16);
    chk("idle.resp_valid", 64'(resp_valid), 64'd0);

    upd(64'h1000, 64'h2000, 1'b1, 1'b0, 1'b0);
    lookup("train", 64'h1000, 1'b1, 64'h2000, 1'b1, 1'b0);
    tick();
    chk("gap.vld", 64'(resp_valid), 64'd0);

    // Replacement in set 0: overwrite in place, fill free way, then round-robin.
    upd(64'h1000, 64'hA000, 1'b0, 1'b0, 1'b0);
    lookup("ovw", 64'h1000, 1'b1, 64'hA000, 1'b0, 1'b0);
    upd(64'h1020, 64'hB000, 1'b0, 1'b1, 1'b0);
    upd(64'h1040, 64'hC000, 1'b1, 1'b0, 1'b0);
    lookup("repl.1000", 64'h1000, 1'b0, 64'h0, 1'b0, 1'b0);
    lookup("repl.1020", 64'h1020, 1'b1, 64'hB000, 1'b0, 1'b1);
    lookup("repl.1040", 64'h1040, 1'b1, 64'hC000, 1'b1, 1'b0);
    upd(64'h1060, 64'hD000, 1'b1, 1'b1, 1'b0);
    lookup("repl2.1020", 64'h1020, 1'b0, 64'h0, 1'b0, 1'b0);
    lookup("repl2.1060", 64'h1060, 1'b1, 64'hD000, 1'b1, 1'b1);
    lookup("repl2.1040", 64'h1040, 1'b1, 64'hC000, 1'b1, 1'b0);

    // Read-before-write on untouched set 3.
    update_valid = 1'b1; update_pc = 64'h1006; update_target = 64'hE000;
    update_is_br = 1'b0; update_is_jal = 1'b1;
    req_valid = 1'b1; req_pc = 64'h1006;
    tick();
    update_valid = 1'b0; req_valid = 1'b0;
    chk("rbw.vld", 64'(resp_valid), 64'd1);
    chk("rbw.hit", 64'(resp_hit), 64'd0);
    lookup("rbw.again", 64'h1006, 1'b1, 64'hE000, 1'b0, 1'b1);

    // Invalidate; pointer must stay put across invalidate and free-way fill.
    upd(64'h1000, 64'hF000, 1'b0, 1'b1, 1'b0);
    lookup("inv.pre", 64'h1000, 1'b1, 64'hF000, 1'b0, 1'b1);
    upd(64'h1000, 64'h0, 1'b0, 1'b0, 1'b1);
    lookup("inv.post", 64'h1000, 1'b0, 64'h0, 1'b0, 1'b0);
    upd(64'h3000, 64'h0, 1'b0, 1'b0, 1'b1);
    lookup("inv.absent", 64'h1060, 1'b1, 64'hD000, 1'b1, 1'b1);
    upd(64'h1080, 64'h8000, 1'b1, 1'b0, 1'b0);
    upd(64'h10A0, 64'h9000, 1'b0, 1'b1, 1'b0);
    lookup("rr.1060", 64'h1060, 1'b0, 64'h0, 1'b0, 1'b0);
    lookup("rr.1080", 64'h1080, 1'b1, 64'h8000, 1'b1, 1'b0);
    lookup("rr.10A0", 64'h10A0, 1'b1, 64'h9000, 1'b0, 1'b1);

    // Flush: 16 busy cycles, an update during the sweep is dropped.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 3) begin
        update_valid = 1'b1; update_pc = 64'h100A; update_target = 64'h5555;
        update_is_br = 1'b1; update_is_jal = 1'b0;
      end
      tick();
      update_valid = 1'b0;
    end
    chk("flush_len", 64'(n), 64'd16);
    lookup("fl.1080", 64'h1080, 1'b0, 64'h0, 1'b0, 1'b0);
    lookup("fl.10A0", 64'h10A0, 1'b0, 64'h0, 1'b0, 1'b0);
    lookup("fl.1006", 64'h1006, 1'b0, 64'h0, 1'b0, 1'b0);
    lookup("fl.drop", 64'h100A, 1'b0, 64'h0, 1'b0, 1'b0);

    // Reset at sweep cycle 5 squashes the pending response and restarts the sweep.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (4) tick();
    req_valid = 1'b1; req_pc = 64'h1080;
    tick();
    req_valid = 1'b0;
    chk("midsweep.vld", 64'(resp_valid), 64'd1);
    chk("midsweep.hit", 64'(resp_hit), 64'd0);
    reset = 1'b0;
    #1;
    chk("squash.vld", 64'(resp_valid), 64'd0);
    chk("squash.busy", 64'(busy), 64'd1);
    tick();
    reset = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("restart_len", 64'(n), 64'd16);
    lookup("post_rst", 64'h1080, 1'b0, 64'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
